// File: rtl/lfsr_gen.sv
// Fibonacci XNOR LFSR with seed load, forced step and a 2**DIV_BITS step-rate divider.
// Define LFSR_LOCKUP_RECOVER_EN to map any all-ones write of the state to all-zeros.
module lfsr_gen #(
    parameter int unsigned     WIDTH    = 6,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(6'h30),
    parameter int unsigned     DIV_BITS = 11,
    parameter int unsigned     OUT_W    = 4,
    parameter int unsigned     OUT_LSB  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step_now,
    output logic [OUT_W-1:0] out_rand,
    output logic [WIDTH-1:0] state,
    output logic             stepped
);

    logic [WIDTH-1:0]    ps_q, ps_d;
    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic                stepped_q, stepped_d;

    logic                fb;
    logic [WIDTH-1:0]    ps_step;
    logic [WIDTH-1:0]    ps_wr;

    always_comb begin
        fb        = ~^(ps_q & TAPS);
        ps_step   = {ps_q[WIDTH-2:0], fb};
        ps_wr     = ps_q;
        cnt_d     = cnt_q;
        stepped_d = 1'b0;

        if (load) begin
            ps_wr = seed;
            cnt_d = '0;
        end else if (step_now) begin
            ps_wr     = ps_step;
            cnt_d     = '0;
            stepped_d = 1'b1;
        end else if (en) begin
            if (&cnt_q) begin
                ps_wr     = ps_step;
                cnt_d     = '0;
                stepped_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_BITS'(1);
            end
        end

`ifdef LFSR_LOCKUP_RECOVER_EN
        // All-ones is the XNOR fixed point; never let it into the register.
        ps_d = (&ps_wr) ? '0 : ps_wr;
`else
        ps_d = ps_wr;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q      <= '0;
            cnt_q     <= '0;
            stepped_q <= 1'b0;
        end else begin
            ps_q      <= ps_d;
            cnt_q     <= cnt_d;
            stepped_q <= stepped_d;
        end
    end

    assign state    = ps_q;
    assign out_rand = ps_q[OUT_LSB +: OUT_W];
    assign stepped  = stepped_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen with WIDTH=6, TAPS=6'h30, DIV_BITS=2, OUT_W=4, OUT_LSB=1.
// Honours LFSR_LOCKUP_RECOVER_EN to pick the expected lock-up behaviour.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       load;
    logic [5:0] seed;
    logic       step_now;
    logic [3:0] out_rand;
    logic [5:0] state;
    logic       stepped;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_gen #(
        .WIDTH   (6),
        .TAPS    (6'h30),
        .DIV_BITS(2),
        .OUT_W   (4),
        .OUT_LSB (1)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .seed    (seed),
        .step_now(step_now),
        .out_rand(out_rand),
        .state   (state),
        .stepped (stepped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; load = 1'b0; step_now = 1'b0; seed = '0;
        tick(1);
        reset = 1'b0;
    endtask

    logic [5:0] exp_seq [5];

    initial begin
        exp_seq[0] = 6'b000011; exp_seq[1] = 6'b000111; exp_seq[2] = 6'b001111;
        exp_seq[3] = 6'b011111; exp_seq[4] = 6'b111110;

        // 1: reset state and first auto steps
        do_reset();
        check("rst_state", 32'(state), 32'h0);
        check("rst_out", 32'(out_rand), 32'h0);
        check("rst_stepped", 32'(stepped), 32'h0);
        en = 1'b1;
        tick(3);
        check("t1_no_early_step", 32'(stepped), 32'h0);
        check("t1_hold", 32'(state), 32'h0);
        tick(1);
        check("t1_step1_pulse", 32'(stepped), 32'h1);
        check("t1_step1_state", 32'(state), 32'h01);
        tick(1);
        check("t1_pulse_clears", 32'(stepped), 32'h0);
        tick(3);
        check("t1_step2", 32'(state), 32'(exp_seq[0]));
        check("t1_out_rand", 32'(out_rand), 32'h1);
        for (int i = 1; i < 5; i++) begin
            tick(4);
            check("t1_seq", 32'(state), 32'(exp_seq[i]));
        end

        // 2: full period from zero
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 63; k++) begin
            tick(4);
            check("t2_never_ones", 32'(state == 6'h3f), 32'h0);
            if (k < 63) check("t2_no_early_zero", 32'(state == 6'h00), 32'h0);
        end
        check("t2_period_63", 32'(state), 32'h0);

        // 3: load mid-count clears the divider
        do_reset();
        en = 1'b1;
        tick(2);
        load = 1'b1; seed = 6'b101010;
        tick(1);
        load = 1'b0;
        check("t3_load_state", 32'(state), 32'h2a);
        check("t3_load_stepped", 32'(stepped), 32'h0);
        tick(3);
        check("t3_no_step_yet", 32'(state), 32'h2a);
        tick(1);
        check("t3_step_state", 32'(state), 32'h14);
        check("t3_step_pulse", 32'(stepped), 32'h1);

        // 4: forced step, then load beats step_now
        do_reset();
        load = 1'b1; seed = 6'b000001;
        tick(1);
        load = 1'b0;
        en = 1'b1;
        tick(2);
        en = 1'b0;
        step_now = 1'b1;
        tick(1);
        step_now = 1'b0;
        check("t4_force_state", 32'(state), 32'h03);
        check("t4_force_pulse", 32'(stepped), 32'h1);
        en = 1'b1;
        tick(3);
        check("t4_cnt_cleared", 32'(state), 32'h03);
        tick(1);
        check("t4_auto_after_force", 32'(state), 32'h07);
        en = 1'b0;
        load = 1'b1; step_now = 1'b1; seed = 6'b000111;
        tick(1);
        load = 1'b0; step_now = 1'b0;
        check("t4_load_wins_state", 32'(state), 32'h07);
        check("t4_load_wins_pulse", 32'(stepped), 32'h0);

        // 5: en freeze resumes phase; reset restarts it
        do_reset();
        en = 1'b1;
        tick(2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t5_frozen", 32'({stepped, state}), 32'h0);
        end
        en = 1'b1;
        tick(1);
        check("t5_resume_wait", 32'(state), 32'h0);
        tick(1);
        check("t5_resume_step", 32'(state), 32'h01);
        check("t5_resume_pulse", 32'(stepped), 32'h1);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_reset_state", 32'(state), 32'h0);
        tick(3);
        check("t5_reset_phase", 32'(state), 32'h0);
        tick(1);
        check("t5_reset_step", 32'(state), 32'h01);

        // 6: all-ones handling
        do_reset();
        load = 1'b1; seed = 6'b111111;
        tick(1);
        load = 1'b0;
        step_now = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
        check("t6_load_recover", 32'(state), 32'h00);
        tick(1);
        step_now = 1'b0;
        check("t6_step_recover", 32'(state), 32'h01);
`else
        check("t6_load_ones", 32'(state), 32'h3f);
        tick(1);
        step_now = 1'b0;
        check("t6_lockup_state", 32'(state), 32'h3f);
`endif
        check("t6_pulse", 32'(stepped), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
